// File: rtl/apb4_slave_if.sv
// APB4 slave front-end: sequences SETUP/ACCESS, holds the transfer stable for
// the register bank and returns PREADY/PRDATA/PSLVERR, with a response timeout.
module apb4_slave_if #(
  parameter int ADDR_W    = 12,
  parameter int DATA_W    = 32,
  parameter int TIMEOUT   = 16,
  parameter int PRIV_ONLY = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  psel,
  input  logic                  penable,
  input  logic                  pwrite,
  input  logic [ADDR_W-1:0]     paddr,
  input  logic [DATA_W-1:0]     pwdata,
  input  logic [DATA_W/8-1:0]   pstrb,
  input  logic [2:0]            pprot,
  output logic                  pready,
  output logic [DATA_W-1:0]     prdata,
  output logic                  pslverr,
  output logic [ADDR_W-1:0]     addr,
  output logic [DATA_W-1:0]     wdata,
  output logic [DATA_W/8-1:0]   w_strb,
  output logic                  write_en,
  output logic                  read_en,
  input  logic [DATA_W-1:0]     rdata,
  input  logic                  rd_ready,
  input  logic                  wr_ready,
  input  logic                  err_resp
);
  localparam int               CNT_W   = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;
  state_t state, state_nxt;

  logic             is_wr;
  logic [CNT_W-1:0] cnt;
  logic             setup, priv_rej, zero_strb, rd_done, wr_done, tmo;
  logic             unused_prot;

  assign unused_prot = &{1'b0, pprot[2:1]};

  assign setup     = (state == IDLE) && psel && !penable;
  assign priv_rej  = (PRIV_ONLY != 0) && !pprot[0];
  assign zero_strb = pwrite && (pstrb == '0);
  assign rd_done   = (state == WAIT) && !is_wr && rd_ready;
  assign wr_done   = (state == WAIT) &&  is_wr && wr_ready;
  // A ready arriving on the last allowed WAIT cycle still wins over the timeout.
  assign tmo       = (state == WAIT) && !rd_done && !wr_done && (cnt == CNT_MAX);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    write_en  = 1'b0;
    read_en   = 1'b0;
    pready    = 1'b0;
    case (state)
      IDLE: begin
        if (setup) state_nxt = (priv_rej || zero_strb) ? RESP : ACCESS;
      end
      ACCESS: begin
        write_en  = is_wr;
        read_en   = !is_wr;
        state_nxt = psel ? WAIT : IDLE;
      end
      WAIT: begin
        read_en = !is_wr;
        if (!psel)                          state_nxt = IDLE;
        else if (rd_done || wr_done || tmo) state_nxt = RESP;
      end
      RESP: begin
        pready    = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr    <= '0;
      wdata   <= '0;
      w_strb  <= '0;
      is_wr   <= 1'b0;
      cnt     <= '0;
      prdata  <= '0;
      pslverr <= 1'b0;
    end else begin
      // Early rejects load their final error flag here and skip the bank.
      if (setup) begin
        addr    <= paddr;
        wdata   <= pwdata;
        w_strb  <= pstrb;
        is_wr   <= pwrite;
        pslverr <= priv_rej;
      end
      if (state == ACCESS) cnt <= '0;
      if (state == WAIT && psel) begin
        if (rd_done) begin
          prdata  <= rdata;
          pslverr <= err_resp;
        end else if (wr_done) begin
          pslverr <= 1'b0;
        end else if (tmo) begin
          prdata  <= '0;
          pslverr <= 1'b1;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
      if (state == RESP) pslverr <= 1'b0;
    end
  end
endmodule
